tx_frame_param: RTL and testbench
=================================

// Module: tx_frame_param
// PURPOSE
//  Parametrised serial frame transmitter: debounces a push-button trigger, latches a
//  data word and an instruction word, and shifts them out LSB-first as one UART-style
//  frame with start bit, optional parity and 1-2 stop bits, at a programmable bit rate.
//  It sits between the board button/switch inputs and the serial link to the receiver.
//  Also provides busy/done status, and fires one frame per press (edge-armed).
// PARAMETERS
//  DATA_W          4   width of dado field (>=1)
//  INSTR_W         4   width of instrucao field (>=1)
//  CLKS_PER_BIT    4   clock cycles per serial bit (>=1)
//  DEBOUNCE_CYCLES 3   consecutive high samples of botao required to trigger (>=1)
//  PARITY          0   0 = none, 1 = even, 2 = odd (over dado and instrucao bits)
//  STOP_BITS       1   number of stop bits, 1 or 2
// PORTS
//  clock      in   1        single clock, all logic on rising edge
//  reset_n    in   1        reset, synchronous, active-low
//  botao      in   1        trigger button, already synchronised, active-high
//  dado       in   DATA_W   data field, sampled at trigger
//  instrucao  in   INSTR_W  instruction field, sampled at trigger
//  out        out  1        serial line, idle high
//  busy       out  1        high while a frame is on the line
//  done       out  1        one-cycle pulse when a frame completes
// BEHAVIOUR
//  - Reset (reset_n=0 at an edge): state IDLE, out=1, busy=0, done=0, counters cleared;
//    latched words are don't-care. Reset mid-frame aborts it: no done pulse.
//  - States: IDLE, DEBOUNCE, SEND, WAIT_RELEASE.
//  - IDLE: botao=1 sampled -> DEBOUNCE, debounce count=1. out=1.
//  - DEBOUNCE: botao=0 -> IDLE (count cleared). Otherwise count increments; on the edge
//    where botao has been sampled high DEBOUNCE_CYCLES consecutive edges, latch dado and
//    instrucao, drive out=0 (start bit), busy=1, enter SEND. With DEBOUNCE_CYCLES=1 the
//    transition IDLE->SEND happens on the first high sample.
//  - SEND: frame = start(0), dado[0..DATA_W-1], instrucao[0..INSTR_W-1], parity bit if
//    PARITY!=0, STOP_BITS x 1. Each bit held exactly CLKS_PER_BIT cycles.
//    Frame length F = (1+DATA_W+INSTR_W+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
//  - Even parity bit = XOR of all latched bits; odd = its inverse.
//  - Inputs dado/instrucao/botao are ignored in SEND; changes have no effect on the frame.
//  - End of last stop bit: busy=0, done=1 for exactly one cycle, out stays 1, state
//    WAIT_RELEASE. busy high exactly F cycles.
//  - WAIT_RELEASE: stays until botao sampled 0, then IDLE. A held button yields one frame.
//  - Bit and debounce counters sized by $clog2; no wrap-around inside a frame.
//  - out is registered; no combinational path from any input to out.
// TESTING (defaults unless stated)
//  1 press botao 5 cycles, dado=4'hA, instrucao=4'h3 -> out = 0,0,1,0,1,1,1,0,0,1 each
//    4 cycles; busy high 40 cycles; single done pulse on the edge busy falls.
//  2 botao high 2 cycles then low -> no frame; out=1, busy=0, done=0 throughout.
//  3 botao held 200 cycles -> exactly one frame and one done; second press after
//    release -> second identical frame.
//  4 PARITY=1, dado=4'h7, instrucao=4'h1 -> parity bit 0; PARITY=2 -> 1; STOP_BITS=2 ->
//    frame 12 bits, busy 48 cycles.
//  5 reset_n low at cycle 15 of a frame -> next edge out=1, busy=0, no done; a new press
//    after reset_n=1 produces a full correct frame.
//  6 dado changed 4'hA->4'h5 mid-frame -> transmitted bits still encode 4'hA.

Source files
------------

// File: rtl/tx_frame_param_if.sv
// Button/word inputs and serial/status outputs of the frame transmitter.
// The slave modport is the transmitter's view; master is the stimulus side.
interface tx_frame_param_if #(
    parameter int DATA_W  = 4,
    parameter int INSTR_W = 4
);
    logic               botao;
    logic [DATA_W-1:0]  dado;
    logic [INSTR_W-1:0] instrucao;
    logic               out;
    logic               busy;
    logic               done;

    modport master (
        output botao,
        output dado,
        output instrucao,
        input  out,
        input  busy,
        input  done
    );

    modport slave (
        input  botao,
        input  dado,
        input  instrucao,
        output out,
        output busy,
        output done
    );
endinterface

// File: rtl/tx_frame_param.sv
// Debounced, edge-armed UART-style transmitter: start bit, dado, instrucao,
// optional parity and 1-2 stop bits, each bit held CLKS_PER_BIT cycles.
module tx_frame_param #(
    parameter int DATA_W          = 4,
    parameter int INSTR_W         = 4,
    parameter int CLKS_PER_BIT    = 4,
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    tx_frame_param_if.slave    bus
);
    localparam int PAR_EN  = (PARITY != 0) ? 1 : 0;
    localparam int BODY_W  = 1 + DATA_W + INSTR_W;
    localparam int NBITS   = BODY_W + PAR_EN + STOP_BITS;
    localparam int BIT_W   = $clog2(NBITS);
    localparam int CLK_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic PAR_ODD = (PARITY == 2) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_DEBOUNCE     = 2'd1,
        ST_SEND         = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } state_t;

    function automatic logic f_parity(input logic [DATA_W+INSTR_W-1:0] bits,
                                      input logic odd);
        return (^bits) ^ odd;
    endfunction

    state_t             r_state;
    logic [DEB_W-1:0]   r_deb_cnt;
    logic [CLK_W-1:0]   r_clk_cnt;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [NBITS-1:0]   r_shift;
    logic               r_out;
    logic               r_busy;
    logic               r_done;

    state_t             w_state_nxt;
    logic [DEB_W-1:0]   w_deb_nxt;
    logic [CLK_W-1:0]   w_clk_nxt;
    logic [BIT_W-1:0]   w_bit_nxt;
    logic [NBITS-1:0]   w_shift_nxt;
    logic               w_out_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    logic [BODY_W-1:0]  w_body;
    logic               w_par;
    logic [NBITS-1:0]   w_frame;

    // Frame image in transmit order: bit 0 (start) goes out first.
    assign w_body = {bus.instrucao, bus.dado, 1'b0};
    assign w_par  = f_parity({bus.instrucao, bus.dado}, PAR_ODD);

    generate
        if (PAR_EN != 0) begin : g_par
            assign w_frame = {{STOP_BITS{1'b1}}, w_par, w_body};
        end else begin : g_nopar
            assign w_frame = {{STOP_BITS{1'b1}}, w_body};
        end
    endgenerate

    // Next-state and next-register logic for the transmit FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_deb_nxt   = r_deb_cnt;
        w_clk_nxt   = r_clk_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_out_nxt   = r_out;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_out_nxt  = 1'b1;
                w_busy_nxt = 1'b0;
                if (bus.botao) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_state_nxt = ST_SEND;
                        w_deb_nxt   = '0;
                        w_clk_nxt   = '0;
                        w_bit_nxt   = '0;
                        w_out_nxt   = w_frame[0];
                        w_shift_nxt = {1'b1, w_frame[NBITS-1:1]};
                        w_busy_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_DEBOUNCE;
                        w_deb_nxt   = DEB_W'(1);
                    end
                end else begin
                    w_deb_nxt = '0;
                end
            end
            ST_DEBOUNCE: begin
                if (!bus.botao) begin
                    w_state_nxt = ST_IDLE;
                    w_deb_nxt   = '0;
                end else if (r_deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                    // Words are captured here; later input changes cannot reach the line.
                    w_state_nxt = ST_SEND;
                    w_deb_nxt   = '0;
                    w_clk_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_out_nxt   = w_frame[0];
                    w_shift_nxt = {1'b1, w_frame[NBITS-1:1]};
                    w_busy_nxt  = 1'b1;
                end else begin
                    w_deb_nxt = r_deb_cnt + DEB_W'(1);
                end
            end
            ST_SEND: begin
                if (r_clk_cnt == CLK_W'(CLKS_PER_BIT - 1)) begin
                    w_clk_nxt = '0;
                    if (r_bit_cnt == BIT_W'(NBITS - 1)) begin
                        w_state_nxt = ST_WAIT_RELEASE;
                        w_bit_nxt   = '0;
                        w_out_nxt   = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_bit_nxt   = r_bit_cnt + BIT_W'(1);
                        w_out_nxt   = r_shift[0];
                        w_shift_nxt = {1'b1, r_shift[NBITS-1:1]};
                    end
                end else begin
                    w_clk_nxt = r_clk_cnt + CLK_W'(1);
                end
            end
            ST_WAIT_RELEASE: begin
                w_out_nxt  = 1'b1;
                w_busy_nxt = 1'b0;
                if (!bus.botao) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT_RELEASE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_deb_nxt   = '0;
                w_clk_nxt   = '0;
                w_bit_nxt   = '0;
                w_out_nxt   = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_deb_cnt <= '0;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '1;
            r_out     <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_deb_cnt <= w_deb_nxt;
            r_clk_cnt <= w_clk_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_out     <= w_out_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign bus.out  = r_out;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
endmodule

// File: tb/tb_tx_frame_param.sv
// Directed bench for tx_frame_param: three instances (no parity, even parity,
// odd parity with two stop bits) checked against hand-computed frames.
module tb_tx_frame_param;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    tx_frame_param_if #(.DATA_W(4), .INSTR_W(4)) if0 ();
    tx_frame_param_if #(.DATA_W(4), .INSTR_W(4)) if1 ();
    tx_frame_param_if #(.DATA_W(4), .INSTR_W(4)) if2 ();

    tx_frame_param u0 (.clock(clock), .reset_n(reset_n), .bus(if0));
    tx_frame_param #(.PARITY(1)) u1 (.clock(clock), .reset_n(reset_n), .bus(if1));
    tx_frame_param #(.PARITY(2), .STOP_BITS(2)) u2 (.clock(clock), .reset_n(reset_n), .bus(if2));

    logic [2:0] m_out, m_busy, m_done;
    assign m_out  = {if2.out,  if1.out,  if0.out};
    assign m_busy = {if2.busy, if1.busy, if0.busy};
    assign m_done = {if2.done, if1.done, if0.done};

    int n_err = 0;
    int n_chk = 0;

    logic rec [3][256];
    int   rec_n [3];
    int   done_cnt [3];
    int   done_bad [3];
    int   out_bad [3];
    logic prev_busy [3];

    typedef struct {
        int          dut;
        logic [3:0]  dado;
        logic [3:0]  instr;
        logic [11:0] exp_bits;   // bit j = j-th transmitted bit
        int          nbits;
    } vec_t;

    vec_t vecs [6];

    // Per-cycle monitor: records the line while busy and audits idle level and done timing.
    always @(negedge clock) begin
        for (int k = 0; k < 3; k++) begin
            if (!reset_n) begin
                prev_busy[k] = 1'b0;
            end else begin
                if (m_busy[k]) begin
                    if (rec_n[k] < 256) rec[k][rec_n[k]] = m_out[k];
                    rec_n[k]++;
                end else if (m_out[k] !== 1'b1) begin
                    out_bad[k]++;
                end
                if (m_done[k] === 1'b1) done_cnt[k]++;
                if (m_done[k] !== (prev_busy[k] && !m_busy[k])) done_bad[k]++;
                prev_busy[k] = m_busy[k];
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        for (int k = 0; k < 3; k++) begin
            rec_n[k] = 0; done_cnt[k] = 0; done_bad[k] = 0; out_bad[k] = 0;
        end
    endtask

    task automatic set_words(input logic [3:0] d, input logic [3:0] i);
        if0.dado = d; if1.dado = d; if2.dado = d;
        if0.instrucao = i; if1.instrucao = i; if2.instrucao = i;
    endtask

    task automatic set_botao(input logic b);
        if0.botao = b; if1.botao = b; if2.botao = b;
    endtask

    task automatic press(input int hold);
        set_botao(1'b1);
        repeat (hold) @(posedge clock);
        #1 set_botao(1'b0);
    endtask

    task automatic check_frames(input string name, input int k, input logic [11:0] exp,
                                input int nbits, input int nframes);
        int mm;
        mm = 0;
        for (int c = 0; c < rec_n[k] && c < 256; c++) begin
            if (rec[k][c] !== exp[(c / 4) % nbits]) mm++;
        end
        chk({name, " busy_cycles"}, rec_n[k], nbits * 4 * nframes);
        chk({name, " bit_errors"}, mm, 0);
        chk({name, " done_pulses"}, done_cnt[k], nframes);
        chk({name, " done_timing"}, done_bad[k], 0);
        chk({name, " idle_level"}, out_bad[k], 0);
    endtask

    initial begin
        vecs[0] = '{0, 4'hA, 4'h3, 12'b0000_0010_0111_0100, 10};
        vecs[1] = '{0, 4'h5, 4'hC, 12'b0011_1000_1010, 10};
        vecs[2] = '{1, 4'h7, 4'h1, 12'b0100_0010_1110, 11};
        vecs[3] = '{2, 4'h7, 4'h1, 12'b1110_0010_1110, 12};
        vecs[4] = '{1, 4'h0, 4'h0, 12'b0100_0000_0000, 11};
        vecs[5] = '{2, 4'hF, 4'h0, 12'b1110_0001_1110, 12};

        set_botao(1'b0);
        set_words(4'h0, 4'h0);
        clear_mon();
        repeat (3) @(posedge clock);
        #1;
        chk("reset out",  int'(m_out),  7);
        chk("reset busy", int'(m_busy), 0);
        chk("reset done", int'(m_done), 0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Table-driven frames.
        for (int v = 0; v < 6; v++) begin
            clear_mon();
            set_words(vecs[v].dado, vecs[v].instr);
            press(5);
            repeat (60) @(posedge clock);
            #1;
            check_frames($sformatf("vec%0d", v), vecs[v].dut, vecs[v].exp_bits,
                         vecs[v].nbits, 1);
        end

        // Short press: debounce rejects it.
        clear_mon();
        set_words(4'hA, 4'h3);
        press(2);
        repeat (60) @(posedge clock);
        #1;
        chk("short busy_cycles", rec_n[0], 0);
        chk("short done_pulses", done_cnt[0], 0);
        chk("short idle_level", out_bad[0], 0);

        // Held button: one frame, then a second press gives an identical frame.
        clear_mon();
        press(200);
        repeat (20) @(posedge clock);
        #1;
        check_frames("held", 0, vecs[0].exp_bits, 10, 1);
        press(5);
        repeat (60) @(posedge clock);
        #1;
        check_frames("repress", 0, vecs[0].exp_bits, 10, 2);

        // Reset in the middle of a frame.
        clear_mon();
        set_botao(1'b1);
        for (int i = 0; i < 20 && !m_busy[0]; i++) begin
            @(posedge clock); #1;
        end
        chk("abort busy_rise", int'(m_busy[0]), 1);
        set_botao(1'b0);
        repeat (15) @(posedge clock);
        #1 reset_n = 1'b0;
        @(posedge clock); #1;
        chk("abort out",  int'(m_out[0]),  1);
        chk("abort busy", int'(m_busy[0]), 0);
        chk("abort done", int'(m_done[0]), 0);
        clear_mon();
        reset_n = 1'b1;
        repeat (30) @(posedge clock);
        #1;
        chk("abort no_done", done_cnt[0], 0);
        chk("abort no_busy", rec_n[0], 0);
        clear_mon();
        press(5);
        repeat (60) @(posedge clock);
        #1;
        check_frames("after_reset", 0, vecs[0].exp_bits, 10, 1);

        // Inputs change mid-frame; the latched words must still go out.
        clear_mon();
        set_words(4'hA, 4'h3);
        press(5);
        repeat (10) @(posedge clock);
        #1 set_words(4'h5, 4'hC);
        set_botao(1'b1);
        repeat (10) @(posedge clock);
        #1 set_botao(1'b0);
        repeat (50) @(posedge clock);
        #1;
        check_frames("midchange", 0, vecs[0].exp_bits, 10, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
